// File: rtl/mem_responder.sv
// mem_responder: single-port word memory target with valid/ready request and
// response channels, programmable wait states and byte-enabled stores.
// Ports:
//   i_clk, i_rstn                 clock, async active-low reset
//   i_req_valid / o_req_ready     request handshake
//   i_req_we, i_req_addr          1 = store / 0 = load, byte address
//   i_req_wdata, i_req_be         store data and byte enables
//   o_rsp_valid / i_rsp_ready     response handshake
//   o_rsp_rdata, o_rsp_err        load data (0 for stores/errors), error flag
module mem_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_be,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [31:0]        mem [DEPTH];

  // Access fields: live request when committing straight from IDLE (LATENCY=0),
  // otherwise the latched copy.
  logic               acc_we_c;
  logic [31:0]        acc_addr_c;
  logic [31:0]        acc_wdata_c;
  logic [3:0]         acc_be_c;
  logic [ADDR_W-1:0]  acc_idx_c;
  logic               acc_err_c;
  logic               commit_c;
  logic               mem_we_c;

  always_comb begin
    if (state_q == S_IDLE) begin
      acc_we_c    = i_req_we;
      acc_addr_c  = i_req_addr;
      acc_wdata_c = i_req_wdata;
      acc_be_c    = i_req_be;
    end else begin
      acc_we_c    = we_q;
      acc_addr_c  = addr_q;
      acc_wdata_c = wdata_q;
      acc_be_c    = be_q;
    end
    acc_idx_c = acc_addr_c[ADDR_W+1:2];
    acc_err_c = (acc_addr_c[1:0] != 2'b00) ||
                ((acc_addr_c >> (ADDR_W + 2)) != 32'd0);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    commit_c    = 1'b0;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;

    case (state_q)
      S_IDLE: begin
        if (i_req_valid && req_ready_q) begin
          we_d    = i_req_we;
          addr_d  = i_req_addr;
          wdata_d = i_req_wdata;
          be_d    = i_req_be;
          cnt_d   = CNT_INIT;
          if (LATENCY == 0) begin
            state_d  = S_RESP;
            commit_c = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = S_RESP;
          commit_c = 1'b1;
        end else begin
          cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Response payload is captured on the commit edge and then held.
    if (commit_c) begin
      err_d   = acc_err_c;
      rdata_d = (acc_err_c || acc_we_c) ? 32'd0 : mem[acc_idx_c];
    end

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  // Stores never commit while reset is asserted.
  assign mem_we_c = commit_c && acc_we_c && !acc_err_c && i_rstn;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Memory array: no reset, contents persist across reset.
  always_ff @(posedge i_clk) begin
    if (mem_we_c) begin
      for (int n = 0; n < 4; n++) begin
        if (acc_be_c[n]) begin
          mem[acc_idx_c][8*n +: 8] <= acc_wdata_c[8*n +: 8];
        end
      end
    end
  end

  assign o_req_ready = req_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;

endmodule

// File: doc/mem_responder.md
# mem_responder

Single-port word-organised memory target that answers the load/store requests issued by the DATAPATH's memory interface: it accepts one request through a valid/ready handshake, applies a programmable number of wait states, commits writes with byte enables, and returns read data and an error flag through a valid/ready response channel. It sits on the datapath's data-memory port and serves as the bus-level responder for both simulation benches and synthesis.

## Interface
- ADDR_W, 10, word-address width; depth = 2^ADDR_W 32-bit words (byte range 0 .. 4*2^ADDR_W-1)
- LATENCY, 1, wait states between acceptance and response, legal range 0..7
- i_clk  in  1  clock, all state updates on rising edge
- i_rstn  in  1  reset; one clock, reset is asynchronous and active-low
- i_req_valid  in  1  request present
- o_req_ready  out  1  responder can accept a request
- i_req_we  in  1  1 = store, 0 = load
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data
- i_req_be  in  4  byte enables (bit n writes wdata[8n+7:8n]); ignored for loads
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  requester takes response
- o_rsp_rdata  out  32  load data (full word); 0 for stores and errors
- o_rsp_err  out  1  access rejected

## Operation
- FSM states IDLE, WAIT, RESP; 3-bit wait counter.
- IDLE: o_req_ready=1. On i_req_valid & o_req_ready at an edge: latch we, addr, wdata, be; go to WAIT with counter=LATENCY-1, or straight to RESP if LATENCY=0.
- WAIT: o_req_ready=0, o_rsp_valid=0; counter decrements each edge; at the edge where counter=0, go to RESP.
- Memory access (commit) happens on the edge that enters RESP: stores write enabled bytes; loads capture the word into o_rsp_rdata (post-write contents, so a store followed by a load to the same word returns new data).
- RESP: o_rsp_valid=1, outputs held stable until i_rsp_ready=1 at an edge; then IDLE, o_rsp_valid=0.
- Error: addr[1:0]!=0 or addr >= 4*2^ADDR_W -> no memory write, o_rsp_rdata=0, o_rsp_err=1. Store with be=4'b0000 is legal, writes nothing, err=0.
- Word index = addr[ADDR_W+1:2]. Memory array is not reset; contents persist across reset.
- One outstanding request; o_req_ready is 0 in WAIT and RESP.

## Timing
- Reset values (async, while i_rstn=0): state IDLE, o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, counter 0. Requests presented while i_rstn=0 are not accepted.
- Acceptance edge T0: o_rsp_valid rises after edge T0+LATENCY (LATENCY=0 -> valid in the cycle right after T0).
- Response with i_rsp_ready held 1: o_rsp_valid high exactly one cycle; o_req_ready returns 1 the next cycle. Minimum request spacing LATENCY+2 cycles.
- Backpressure: i_rsp_ready=0 holds RESP indefinitely with o_rsp_rdata/o_rsp_err unchanged.
- Reset mid-operation: asserting i_rstn in WAIT drops the pending store (not committed); in RESP the response is discarded (store already committed). FSM resumes in IDLE.
- o_req_ready and o_rsp_valid are decoded from state only, never from i_req_valid or i_rsp_ready (no combinational path input->output).

## Test plan
- LATENCY=1: store addr 0x10, wdata 0xDEADBEEF, be 4'hF, then load 0x10 -> rdata 0xDEADBEEF, err 0; o_rsp_valid rises 2 cycles after each acceptance edge.
- Partial store: word 0x20 holds 0x11223344; store wdata 0xAABBCCDD be 4'b0101 -> load 0x20 returns 0x11BB33DD.
- Errors: load 0x13 -> err 1, rdata 0; store 0x1000 with ADDR_W=10 -> err 1, subsequent load 0xFFC unchanged.
- Backpressure: hold i_rsp_ready=0 for 5 cycles in RESP -> o_rsp_valid stays 1, data stable, o_req_ready 0; release -> IDLE next cycle.
- LATENCY=0 and LATENCY=7: measured acceptance-to-valid distance 1 and 8 cycles respectively; back-to-back requests spaced 2 and 9 cycles.
- Reset during WAIT of a store to 0x40 (LATENCY=3): after reset o_rsp_valid=0, o_req_ready=1; load 0x40 returns prior contents.
